// File: rtl/te_seq_pkg.sv
// Shared types and constants for the multi-channel radio enable sequencer.
// Optional feature macro: TE_SEQ_LOSS_CNT_EN (per-channel lock-loss counters).
package te_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_ENABLED = 3'd2,
        ST_RX_ON   = 3'd3,
        ST_DRAIN   = 3'd4
    } te_seq_state_e;

    localparam int LOSS_CNT_W = 8;

    // Larger of two integers, used to size the shared settle/guard counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/te_seq_chan.sv
// One channel of the radio enable sequencer: FSM, settle/guard counter and,
// when TE_SEQ_LOSS_CNT_EN is defined, a saturating lock-loss counter.
module te_seq_chan
    import te_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int GUARD_CYCLES  = 2
) (
    input  logic                  ck,
    input  logic                  arst,
    input  logic                  chan_en,
    input  logic                  pll_settled,
    input  logic                  rx_req,
`ifdef TE_SEQ_LOSS_CNT_EN
    input  logic                  loss_clr,
    output logic [LOSS_CNT_W-1:0] loss_cnt,
`endif
    output logic                  radio_enable,
    output logic                  radio_rx_en,
    output logic                  lock_lost
);

    // One counter serves both SETTLE and DRAIN; it never wraps because the
    // terminal compare always leaves the state.
    localparam int CNT_W = $clog2(max_int(SETTLE_CYCLES, GUARD_CYCLES) + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    te_seq_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lost_q, lost_d;

    // State, counter and lock-loss pulse registers.
    always_ff @(posedge ck) begin
        if (arst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lost_q  <= lost_d;
        end
    end

    // Next-state logic; a disabled channel drops to IDLE ahead of lock loss.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lost_d  = 1'b0;
        if (!chan_en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pll_settled) begin
                        state_d = ST_SETTLE;
                        cnt_d   = CNT_ONE;
                    end
                end
                ST_SETTLE: begin
                    if (!pll_settled) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_ENABLED;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_ENABLED: begin
                    if (!pll_settled) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        lost_d  = 1'b1;
                    end else if (rx_req) begin
                        state_d = ST_RX_ON;
                    end
                end
                ST_RX_ON: begin
                    if (!pll_settled) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        lost_d  = 1'b1;
                    end else if (!rx_req) begin
                        state_d = ST_DRAIN;
                        cnt_d   = CNT_ONE;
                    end
                end
                ST_DRAIN: begin
                    // RX request is deliberately ignored during the guard.
                    if (!pll_settled) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        lost_d  = 1'b1;
                    end else if (cnt_q == GUARD_LAST) begin
                        state_d = ST_ENABLED;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs decode registered state only, so inputs never reach them directly.
    assign radio_enable = (state_q == ST_ENABLED) || (state_q == ST_RX_ON) ||
                          (state_q == ST_DRAIN);
    assign radio_rx_en  = (state_q == ST_RX_ON);
    assign lock_lost    = lost_q;

`ifdef TE_SEQ_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

    // Saturating count of lock-loss events; clear beats a same-edge increment.
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (loss_clr) begin
            loss_cnt_d = '0;
        end else if (lost_d && (loss_cnt_q != {LOSS_CNT_W{1'b1}})) begin
            loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
        end
    end

    // Loss counter register.
    always_ff @(posedge ck) begin
        if (arst) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign loss_cnt = loss_cnt_q;
`endif

endmodule

// File: rtl/timing_engine_seq.sv
// Multi-channel radio enable sequencer top: N_CH independent channel FSMs.
// Optional feature macro: TE_SEQ_LOSS_CNT_EN adds loss_clr / loss_cnt.
module timing_engine_seq
    import te_seq_pkg::*;
#(
    parameter int N_CH          = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int GUARD_CYCLES  = 2
) (
    input  logic                       ck,
    input  logic                       arst,
    input  logic [N_CH-1:0]            chan_en,
    input  logic [N_CH-1:0]            pll_settled,
    input  logic [N_CH-1:0]            t_arst_fs,
`ifdef TE_SEQ_LOSS_CNT_EN
    input  logic                       loss_clr,
    output logic [N_CH*LOSS_CNT_W-1:0] loss_cnt,
`endif
    output logic [N_CH-1:0]            radio_enable_synced,
    output logic [N_CH-1:0]            radio_rx_en_synced,
    output logic [N_CH-1:0]            lock_lost
);

    // One fully independent sequencer per channel.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
            te_seq_chan #(
                .SETTLE_CYCLES (SETTLE_CYCLES),
                .GUARD_CYCLES  (GUARD_CYCLES)
            ) u_chan (
                .ck           (ck),
                .arst         (arst),
                .chan_en      (chan_en[gi]),
                .pll_settled  (pll_settled[gi]),
                .rx_req       (t_arst_fs[gi]),
`ifdef TE_SEQ_LOSS_CNT_EN
                .loss_clr     (loss_clr),
                .loss_cnt     (loss_cnt[gi*LOSS_CNT_W +: LOSS_CNT_W]),
`endif
                .radio_enable (radio_enable_synced[gi]),
                .radio_rx_en  (radio_rx_en_synced[gi]),
                .lock_lost    (lock_lost[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_timing_engine_seq.sv
// Directed bench for timing_engine_seq (N_CH=2, SETTLE_CYCLES=4, GUARD_CYCLES=2).
// Loss-counter steps are built only when TE_SEQ_LOSS_CNT_EN is defined.
module tb_timing_engine_seq;

    logic       ck;
    logic       arst;
    logic [1:0] chan_en;
    logic [1:0] pll_settled;
    logic [1:0] t_arst_fs;
    logic [1:0] radio_enable_synced;
    logic [1:0] radio_rx_en_synced;
    logic [1:0] lock_lost;
`ifdef TE_SEQ_LOSS_CNT_EN
    logic        loss_clr;
    logic [15:0] loss_cnt;
`endif

    int total = 0;
    int bad   = 0;

    timing_engine_seq #(
        .N_CH          (2),
        .SETTLE_CYCLES (4),
        .GUARD_CYCLES  (2)
    ) dut (
        .ck                  (ck),
        .arst                (arst),
        .chan_en             (chan_en),
        .pll_settled         (pll_settled),
        .t_arst_fs           (t_arst_fs),
`ifdef TE_SEQ_LOSS_CNT_EN
        .loss_clr            (loss_clr),
        .loss_cnt            (loss_cnt),
`endif
        .radio_enable_synced (radio_enable_synced),
        .radio_rx_en_synced  (radio_rx_en_synced),
        .lock_lost           (lock_lost)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Advance one rising edge; sample and drive 1 time unit after it.
    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Checks all three N_CH-wide outputs against {en, rx, lost}.
    task automatic chk_out(input string tag, input logic [1:0] en, input logic [1:0] rx,
                           input logic [1:0] lost);
        chk({tag, ".en"},   {14'd0, radio_enable_synced}, {14'd0, en});
        chk({tag, ".rx"},   {14'd0, radio_rx_en_synced},  {14'd0, rx});
        chk({tag, ".lost"}, {14'd0, lock_lost},           {14'd0, lost});
    endtask

    initial begin
        // Reset held 3 cycles with every input high.
        arst        = 1'b1;
        chan_en     = 2'b11;
        pll_settled = 2'b11;
        t_arst_fs   = 2'b11;
`ifdef TE_SEQ_LOSS_CNT_EN
        loss_clr    = 1'b0;
`endif
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("rst%0d", i), 2'b00, 2'b00, 2'b00);
        end
        arst = 1'b0;
        step();                                   // IDLE -> SETTLE
        chk_out("rst_rel", 2'b00, 2'b00, 2'b00);

        // Clean restart for the settle scenario.
        arst = 1'b1; pll_settled = 2'b00; t_arst_fs = 2'b00;
        step();
        arst = 1'b0;
        pll_settled = 2'b11;
        step();                                   // e0
        step();                                   // e1
        pll_settled = 2'b01;                      // ch1 low at e2
        step();                                   // e2
        chk_out("settle_e2", 2'b00, 2'b00, 2'b00);
        step();                                   // e3
        chk_out("settle_e3", 2'b00, 2'b00, 2'b00);
        step();                                   // e4
        chk_out("settle_e4", 2'b01, 2'b00, 2'b00);

        // RX burst: request sampled at 5 edges, then dropped.
        t_arst_fs = 2'b01;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out($sformatf("rx_on%0d", i), 2'b01, 2'b01, 2'b00);
        end
        t_arst_fs = 2'b00;
        step();                                   // d0
        chk_out("drain_d0", 2'b01, 2'b00, 2'b00);
        t_arst_fs = 2'b01;                        // held through DRAIN
        step();                                   // d1
        chk_out("drain_d1", 2'b01, 2'b00, 2'b00);
        step();                                   // d2: re-armed
        chk_out("drain_d2", 2'b01, 2'b00, 2'b00);
        step();                                   // d3: RX_ON again
        chk_out("rearm_d3", 2'b01, 2'b01, 2'b00);

        // Lock loss during RX_ON, then full resettle.
        pll_settled = 2'b00;
        step();                                   // L
        chk_out("loss_L", 2'b00, 2'b00, 2'b01);
        pll_settled = 2'b01;
        step();                                   // L+1 = new e0
        chk_out("loss_L1", 2'b00, 2'b00, 2'b00);
        step(); step(); step();                   // e1..e3
        chk_out("resettle_e3", 2'b00, 2'b00, 2'b00);
        step();                                   // e4
        chk_out("resettle_e4", 2'b01, 2'b00, 2'b00);

        // Both channels up, then ch1 loses lock while ch0 is disabled.
        arst = 1'b1; pll_settled = 2'b11; t_arst_fs = 2'b00;
        step();
        arst = 1'b0;
        for (int i = 0; i < 5; i++) step();       // e0..e4
        chk_out("both_up", 2'b11, 2'b00, 2'b00);
        chan_en     = 2'b10;
        pll_settled = 2'b00;
        step();
        chk_out("dis_vs_loss", 2'b00, 2'b00, 2'b10);
        step();
        chk_out("dis_vs_loss1", 2'b00, 2'b00, 2'b00);

`ifdef TE_SEQ_LOSS_CNT_EN
        // 300 lock losses on ch0 saturate its counter; ch1 untouched.
        chan_en = 2'b11;
        arst = 1'b1; step(); arst = 1'b0;
        chk("lcnt_rst", loss_cnt, 16'h0000);
        for (int i = 0; i < 300; i++) begin
            pll_settled = 2'b01;
            for (int k = 0; k < 5; k++) step();
            pll_settled = 2'b00;
            step();
        end
        chk("lcnt_sat", loss_cnt, 16'h00ff);
        loss_clr = 1'b1;
        step();
        loss_clr = 1'b0;
        chk("lcnt_clr", loss_cnt, 16'h0000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
